data_buffer_ctrl: RTL and testbench

Owns the 64-byte endpoint data buffer and arbitrates it between the AHB slave side (multi-byte host reads/writes) and the USB side (byte-serial RX store, TX fetch). Maintains read/write pointers and occupancy, resolves same-cycle conflicts, and performs flush. Sits between the AHB slave, the USB RX/TX engines and the buffer storage.

---
 rtl/data_buffer_ctrl_pkg.sv | 20 ++
 rtl/data_buffer_ram.sv | 23 ++
 rtl/data_buffer_ctrl.sv | 141 ++++++++++++++
 tb/tb_data_buffer_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_buffer_ctrl_pkg.sv
// data_buffer_ctrl_pkg: shared FSM state, pointer widths and byte-count decode for the endpoint buffer
// The PENDING state exists only when DATA_BUFFER_CTRL_SKID_EN is defined.
package data_buffer_ctrl_pkg;
    localparam int DEPTH = 64;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DATA_BUFFER_CTRL_SKID_EN
        PENDING = 2'd1,
`endif
        FLUSH = 2'd2
    } state_t;

    // 2-bit transfer code to byte count: 0/1/2 map directly, 3 means a full word
    function automatic logic [2:0] byte_count(input logic [1:0] code);
        return (code == 2'd3) ? 3'd4 : {1'b0, code};
    endfunction
endpackage

// File: rtl/data_buffer_ram.sv
// data_buffer_ram: unreset byte register file with four wrapping write lanes and four wrapping read lanes
module data_buffer_ram
    import data_buffer_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [31:0]      rdata
);
    logic [7:0] mem [DEPTH];

    // each enabled lane writes the next consecutive address, wrapping at the top
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[waddr + PTR_W'(i)] <= wdata[8*i +: 8];
    end

    for (genvar i = 0; i < 4; i++) begin : g_rd
        assign rdata[8*i +: 8] = mem[raddr + PTR_W'(i)];
    end
endmodule

// File: rtl/data_buffer_ctrl.sv
// data_buffer_ctrl: arbitrates the 64-byte endpoint buffer between AHB word access and USB byte streams
// Define DATA_BUFFER_CTRL_SKID_EN to defer a colliding AHB push through a skid register instead of dropping it.
module data_buffer_ctrl
    import data_buffer_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             d_mode,
    input  logic [1:0]       get_rx_data,
    input  logic [1:0]       store_tx_data,
    input  logic [31:0]      tx_data,
    output logic [31:0]      rx_data,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             get_tx_packet_data,
    output logic [7:0]       tx_packet_data,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic             busy,
    output logic             overflow,
    output logic             underflow,
    output logic             conflict
);
    state_t           state, state_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             active, usb_wr, ahb_wr, wr_conflict, rd_conflict;
    logic [2:0]       w_req, r_req, w_act, r_act;
    logic [31:0]      w_data, rd_word;
    logic [OCC_W-1:0] free;
    logic [3:0]       we;
`ifdef DATA_BUFFER_CTRL_SKID_EN
    logic [31:0]      skid_data;
    logic [2:0]       skid_n;
    logic             pending, capture;
`endif

    // requests are only honoured outside a flush and while clear is low
    assign active = (state != FLUSH) && !clear;
    assign usb_wr = active && store_rx_packet_data;
    assign ahb_wr = active && (store_tx_data != 2'd0);
    assign free   = OCC_W'(DEPTH) - buffer_occupancy;

`ifdef DATA_BUFFER_CTRL_SKID_EN
    assign pending     = state == PENDING;
    assign capture     = usb_wr && ahb_wr && !pending;
    assign wr_conflict = ahb_wr && pending;
    assign w_req       = usb_wr ? 3'd1 : pending ? skid_n : ahb_wr ? byte_count(store_tx_data) : 3'd0;
    assign w_data      = usb_wr ? {24'h0, rx_packet_data} : pending ? skid_data : tx_data;
    assign busy        = (state == FLUSH) || pending;
`else
    assign wr_conflict = usb_wr && ahb_wr;
    assign w_req       = usb_wr ? 3'd1 : ahb_wr ? byte_count(store_tx_data) : 3'd0;
    assign w_data      = usb_wr ? {24'h0, rx_packet_data} : tx_data;
    assign busy        = state == FLUSH;
`endif

    // only the direction selected by d_mode may pop; the other side's pop is flagged
    assign r_req       = !active ? 3'd0 : d_mode ? {2'b0, get_tx_packet_data} : byte_count(get_rx_data);
    assign rd_conflict = active && (d_mode ? (get_rx_data != 2'd0) : get_tx_packet_data);

    // clip transfers to free space / occupancy
    assign w_act = (OCC_W'(w_req) > free) ? free[2:0] : w_req;
    assign r_act = (OCC_W'(r_req) > buffer_occupancy) ? buffer_occupancy[2:0] : r_req;
    assign we    = {w_act > 3'd3, w_act > 3'd2, w_act > 3'd1, w_act > 3'd0};

    data_buffer_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (w_data),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    // lanes past the stored data read as zero, so an empty buffer presents zeros
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign rx_data[8*i +: 8] = (buffer_occupancy > OCC_W'(i)) ? rd_word[8*i +: 8] : 8'h0;
    end
    assign tx_packet_data = rx_data[7:0];

    // next state: clear dominates, flush exits once clear drops, the skid drains when USB is quiet
    always_comb begin
        state_d = state;
        if (clear)
            state_d = FLUSH;
        else if (state == FLUSH)
            state_d = IDLE;
`ifdef DATA_BUFFER_CTRL_SKID_EN
        else if (capture)
            state_d = PENDING;
        else if (pending && !usb_wr)
            state_d = IDLE;
`endif
    end

    // state, pointers, occupancy and the one-cycle status flags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            buffer_occupancy <= '0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
            conflict         <= 1'b0;
        end else begin
            state <= state_d;
            if (clear) begin
                wr_ptr           <= '0;
                rd_ptr           <= '0;
                buffer_occupancy <= '0;
                overflow         <= 1'b0;
                underflow        <= 1'b0;
                conflict         <= 1'b0;
            end else begin
                wr_ptr           <= wr_ptr + PTR_W'(w_act);
                rd_ptr           <= rd_ptr + PTR_W'(r_act);
                buffer_occupancy <= buffer_occupancy + OCC_W'(w_act) - OCC_W'(r_act);
                overflow         <= OCC_W'(w_req) > free;
                underflow        <= OCC_W'(r_req) > buffer_occupancy;
                conflict         <= wr_conflict || rd_conflict;
            end
        end
    end

`ifdef DATA_BUFFER_CTRL_SKID_EN
    // skid holds the AHB push that lost to a same-cycle USB byte
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            skid_data <= '0;
            skid_n    <= '0;
        end else if (clear) begin
            skid_data <= '0;
            skid_n    <= '0;
        end else if (capture) begin
            skid_data <= tx_data;
            skid_n    <= byte_count(store_tx_data);
        end
    end
`endif
endmodule

// File: tb/tb_data_buffer_ctrl.sv
// tb_data_buffer_ctrl: directed self-checking bench for data_buffer_ctrl
module tb_data_buffer_ctrl;
    logic        clk = 1'b0;
    logic        n_rst, clear, d_mode;
    logic [1:0]  get_rx_data, store_tx_data;
    logic [31:0] tx_data, rx_data;
    logic        store_rx_packet_data, get_tx_packet_data;
    logic [7:0]  rx_packet_data, tx_packet_data;
    logic [6:0]  buffer_occupancy;
    logic        busy, overflow, underflow, conflict;
    int          checks = 0;
    int          errors = 0;

    data_buffer_ctrl dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .d_mode               (d_mode),
        .get_rx_data          (get_rx_data),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy),
        .busy                 (busy),
        .overflow             (overflow),
        .underflow            (underflow),
        .conflict             (conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ahb(input logic [1:0] code, input logic [31:0] data);
        store_tx_data = code;
        tx_data = data;
        tick();
        store_tx_data = 2'd0;
    endtask

    task automatic pop_ahb(input logic [1:0] code);
        get_rx_data = code;
        tick();
        get_rx_data = 2'd0;
    endtask

    task automatic push_usb(input logic [7:0] b);
        store_rx_packet_data = 1'b1;
        rx_packet_data = b;
        tick();
        store_rx_packet_data = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int i);
        return {8'(i*4+3), 8'(i*4+2), 8'(i*4+1), 8'(i*4)} ^ 32'h5A5A_5A5A;
    endfunction

    initial begin
        n_rst = 1'b0;
        clear = 1'b0;
        d_mode = 1'b0;
        get_rx_data = 2'd0;
        store_tx_data = 2'd0;
        tx_data = 32'h0;
        store_rx_packet_data = 1'b0;
        rx_packet_data = 8'h0;
        get_tx_packet_data = 1'b0;
        #12;
        check("rst_occ", 32'(buffer_occupancy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {29'd0, overflow, underflow, conflict}, 32'd0);
        check("rst_rx", rx_data, 32'h0);
        check("rst_tx", 32'(tx_packet_data), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;

        // word push then word pop
        push_ahb(2'd3, 32'hDDCC_BBAA);
        check("t1_occ4", 32'(buffer_occupancy), 32'd4);
        check("t1_rx", rx_data, 32'hDDCC_BBAA);
        pop_ahb(2'd3);
        check("t1_occ0", 32'(buffer_occupancy), 32'd0);
        check("t1_unf", 32'(underflow), 32'd0);

        // USB byte and AHB push in the same cycle
        store_rx_packet_data = 1'b1;
        rx_packet_data = 8'h11;
        store_tx_data = 2'd1;
        tx_data = 32'h0000_0022;
        tick();
        store_rx_packet_data = 1'b0;
        store_tx_data = 2'd0;
        check("t2_occ1", 32'(buffer_occupancy), 32'd1);
`ifdef DATA_BUFFER_CTRL_SKID_EN
        check("t2_busy1", 32'(busy), 32'd1);
        check("t2_cfl", 32'(conflict), 32'd0);
        tick();
        check("t2_occ2", 32'(buffer_occupancy), 32'd2);
        check("t2_busy0", 32'(busy), 32'd0);
        check("t2_rx", rx_data, 32'h0000_2211);
        pop_ahb(2'd1);
        check("t2_b1", 32'(rx_data[7:0]), 32'h22);
        pop_ahb(2'd1);
`else
        check("t2_busy0", 32'(busy), 32'd0);
        check("t2_cfl", 32'(conflict), 32'd1);
        tick();
        check("t2_cfl0", 32'(conflict), 32'd0);
        check("t2_rx", rx_data, 32'h0000_0011);
        pop_ahb(2'd1);
`endif
        check("t2_occ0", 32'(buffer_occupancy), 32'd0);

        // fill to 62, then a word push overflows
        for (int k = 0; k < 15; k++) push_ahb(2'd3, {4{8'(k)}});
        push_ahb(2'd2, 32'h0000_BEEF);
        check("t3_occ62", 32'(buffer_occupancy), 32'd62);
        check("t3_ovf0", 32'(overflow), 32'd0);
        push_ahb(2'd3, 32'h4433_2211);
        check("t3_occ64", 32'(buffer_occupancy), 32'd64);
        check("t3_ovf1", 32'(overflow), 32'd1);
        push_usb(8'h99);
        check("t3_ovf_usb", 32'(overflow), 32'd1);
        check("t3_occ_sat", 32'(buffer_occupancy), 32'd64);
        pop_ahb(2'd3);
        check("t3_ovf_clr", 32'(overflow), 32'd0);
        for (int k = 1; k < 15; k++) pop_ahb(2'd3);
        check("t3_occ4", 32'(buffer_occupancy), 32'd4);
        check("t3_tail", rx_data, 32'h2211_BEEF);
        pop_ahb(2'd3);
        check("t3_occ0", 32'(buffer_occupancy), 32'd0);

        // underflow with a single stored byte
        push_usb(8'h5A);
        check("t4_rx", rx_data, 32'h0000_005A);
        pop_ahb(2'd2);
        check("t4_unf1", 32'(underflow), 32'd1);
        check("t4_occ0", 32'(buffer_occupancy), 32'd0);
        tick();
        check("t4_unf0", 32'(underflow), 32'd0);
        push_ahb(2'd1, 32'h0000_0077);
        check("t4_ptr", rx_data, 32'h0000_0077);
        pop_ahb(2'd1);

        // direction arbitration of pops
        push_ahb(2'd2, 32'h0000_A1B2);
        d_mode = 1'b1;
        #1;
        check("t5_tx0", 32'(tx_packet_data), 32'hB2);
        pop_ahb(2'd1);
        check("t5_cfl1", 32'(conflict), 32'd1);
        check("t5_occ2", 32'(buffer_occupancy), 32'd2);
        check("t5_tx_hold", 32'(tx_packet_data), 32'hB2);
        get_tx_packet_data = 1'b1;
        tick();
        check("t5_tx1", 32'(tx_packet_data), 32'hA1);
        check("t5_cfl0", 32'(conflict), 32'd0);
        tick();
        get_tx_packet_data = 1'b0;
        check("t5_occ0", 32'(buffer_occupancy), 32'd0);
        check("t5_tx_empty", 32'(tx_packet_data), 32'h0);
        d_mode = 1'b0;
        push_usb(8'h33);
        get_tx_packet_data = 1'b1;
        tick();
        get_tx_packet_data = 1'b0;
        check("t5_usb_cfl", 32'(conflict), 32'd1);
        check("t5_occ1", 32'(buffer_occupancy), 32'd1);
        pop_ahb(2'd1);
        check("t5_occ_end", 32'(buffer_occupancy), 32'd0);

        // flush with 30 bytes stored and a colliding push
        for (int k = 0; k < 7; k++) push_ahb(2'd3, 32'h0);
        push_ahb(2'd2, 32'h0);
        store_rx_packet_data = 1'b1;
        rx_packet_data = 8'h11;
        store_tx_data = 2'd1;
        tx_data = 32'h22;
        tick();
        check("t6_occ31", 32'(buffer_occupancy), 32'd31);
`ifdef DATA_BUFFER_CTRL_SKID_EN
        check("t6_pend", 32'(busy), 32'd1);
`else
        check("t6_cfl", 32'(conflict), 32'd1);
`endif
        store_tx_data = 2'd3;
        clear = 1'b1;
        tick();
        check("t6_clr_occ", 32'(buffer_occupancy), 32'd0);
        check("t6_clr_busy", 32'(busy), 32'd1);
        check("t6_clr_flags", {29'd0, overflow, underflow, conflict}, 32'd0);
        tick();
        check("t6_hold_occ", 32'(buffer_occupancy), 32'd0);
        check("t6_hold_busy", 32'(busy), 32'd1);
        clear = 1'b0;
        tick();
        store_rx_packet_data = 1'b0;
        store_tx_data = 2'd0;
        check("t6_exit_occ", 32'(buffer_occupancy), 32'd0);
        check("t6_exit_busy", 32'(busy), 32'd0);
        tick();
        check("t6_no_skid", 32'(buffer_occupancy), 32'd0);

        // 72 bytes through the buffer with an odd start offset so words straddle the wrap
        push_usb(8'hAB);
        pop_ahb(2'd1);
        for (int i = 0; i < 16; i++) push_ahb(2'd3, pat(i));
        check("t7_full", 32'(buffer_occupancy), 32'd64);
        check("t7_ovf0", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t7_rd%0d", i), rx_data, pat(i));
            pop_ahb(2'd3);
        end
        for (int i = 16; i < 18; i++) begin
            push_ahb(2'd3, pat(i));
            check($sformatf("t7_rd%0d", i), rx_data, pat(i));
            pop_ahb(2'd3);
        end
        check("t7_occ0", 32'(buffer_occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
